valrdy_rr_arbiter: RTL

Round-robin arbiter that shares one val/rdy output channel among `nreq` val/rdy requesters. It sits upstream of a single consumer, such as a shared val/rdy register stage or a compute unit, and sequences which requester's message is forwarded. The output is registered, so the output channel is a one-entry buffer that sustains one transfer per cycle. The source index of every forwarded message is tagged onto the output.

---
 rtl/valrdy_arb_pkg.sv | 13 +
 rtl/rr_priority_sel.sv | 32 +++
 rtl/valrdy_rr_arbiter.sv | 77 +++++++
 3 files changed

// File: rtl/valrdy_arb_pkg.sv
// Shared definitions for the val/rdy round-robin arbiter.
// Default widths and an index-width helper.
package valrdy_arb_pkg;

   localparam int VALRDY_DEFAULT_BW = 32;
   localparam int ARB_DEFAULT_NREQ  = 4;

   // An index into fewer than two entries still needs one bit.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_priority_sel.sv
// Rotating priority selector: first asserted request at or above ptr,
// wrapping modulo nreq.
module rr_priority_sel
   import valrdy_arb_pkg::*;
#(
   parameter int nreq = ARB_DEFAULT_NREQ,
   parameter int idw  = clog2_min1(nreq)
) (
   input  logic [nreq-1:0] req,
   input  logic [idw-1:0]  ptr,
   output logic [nreq-1:0] gnt_onehot,
   output logic [idw-1:0]  gnt_idx,
   output logic            any
);

   always_comb begin
      int j;
      gnt_onehot = '0;
      gnt_idx    = '0;
      any        = 1'b0;
      for (int k = 0; k < nreq; k++) begin
         j = int'(ptr) + k;
         if (j >= nreq) j = j - nreq;
         if (!any && req[j]) begin
            any           = 1'b1;
            gnt_onehot[j] = 1'b1;
            gnt_idx       = idw'(j);
         end
      end
   end

endmodule

// File: rtl/valrdy_rr_arbiter.sv
// Round-robin arbiter sharing one registered val/rdy output channel
// among nreq requesters; each message is tagged with its source index.
module valrdy_rr_arbiter
   import valrdy_arb_pkg::*;
#(
   parameter int bitwidth = VALRDY_DEFAULT_BW,
   parameter int nreq     = ARB_DEFAULT_NREQ,
   parameter int idw      = clog2_min1(nreq)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [nreq-1:0]          snd_val,
   input  logic [nreq*bitwidth-1:0] snd_msg,
   output logic [nreq-1:0]          snd_rdy,
   output logic                     rcv_val,
   input  logic                     rcv_rdy,
   output logic [bitwidth-1:0]      rcv_msg,
   output logic [idw-1:0]           rcv_src
);

   logic                out_full;
   logic [bitwidth-1:0] out_msg;
   logic [idw-1:0]      out_src;
   logic [idw-1:0]      ptr;

   logic [nreq-1:0]     gnt_onehot;
   logic [idw-1:0]      gnt_idx;
   logic                any;
   logic                can_load;
   logic                in_xfer;
   logic [bitwidth-1:0] msg_sel;

   rr_priority_sel #(
      .nreq (nreq),
      .idw  (idw)
   ) u_sel (
      .req        (snd_val),
      .ptr        (ptr),
      .gnt_onehot (gnt_onehot),
      .gnt_idx    (gnt_idx),
      .any        (any)
   );

   assign can_load = ~out_full | rcv_rdy;
   assign in_xfer  = any & can_load;

   // Reset gating keeps requesters from seeing a ready while the buffer is held clear.
   assign snd_rdy  = (can_load && reset) ? gnt_onehot : '0;

   always_comb begin
      msg_sel = '0;
      for (int i = 0; i < nreq; i++) begin
         if (gnt_idx == idw'(i)) msg_sel = snd_msg[i*bitwidth +: bitwidth];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_full <= 1'b0;
         out_msg  <= '0;
         out_src  <= '0;
         ptr      <= '0;
      end else if (in_xfer) begin
         out_full <= 1'b1;
         out_msg  <= msg_sel;
         out_src  <= gnt_idx;
         ptr      <= (gnt_idx == idw'(nreq-1)) ? '0 : gnt_idx + 1'b1;
      end else if (rcv_rdy) begin
         out_full <= 1'b0;
      end
   end

   assign rcv_val = out_full;
   assign rcv_msg = out_msg;
   assign rcv_src = out_src;

endmodule
